gpu_scanout: RTL and testbench
==============================

# gpu_scanout

Video scanout stage of the Zucker GPU. It generates 1024x768@60 raster timing, fetches framebuffer words from the VRAM graphics read port one line-word at a time, and serialises them into a 1bpp pixel stream with aligned sync and data-enable. It sits directly downstream of the dual-port VRAM: it drives the VRAM graphics address and consumes the VRAM graphics data.

## Interface
Parameters:
- `H_ACTIVE`, default 1024: visible pixels per line.
- `H_FP`, default 24: horizontal front porch, in cycles.
- `H_SYNC`, default 136: hsync width, in cycles.
- `H_BP`, default 160: horizontal back porch. Line total is 1344.
- `V_ACTIVE`, default 768: visible lines per frame.
- `V_FP`, default 3; `V_SYNC`, default 6; `V_BP`, default 29. Frame total is 806 lines.
- `SYNC_NEG`, default 1: sync pulses are active-low.
- `PIXEL_DOUBLE`, default 0: 1 selects 512x384 source, with each pixel and each line shown twice.

Ports:
- `wb_clk_i`, in, 1: the only clock, used as the pixel clock (65 MHz nominal).
- `wb_rst_i`, in, 1: synchronous, active-high reset.
- `en_i`, in, 1: scanout enable. When 0, timing keeps running and `pix_o` is forced to 0.
- `gb_adr_o`, out, 15: VRAM graphics word address.
- `gb_dat_i`, in, 32: VRAM graphics read data. Valid one cycle after the address is presented.
- `pix_o`, out, 1: pixel value.
- `de_o`, out, 1: data enable (active area).
- `hsync_o`, out, 1: horizontal sync.
- `vsync_o`, out, 1: vertical sync.
- `vblank_o`, out, 1: high for all lines with v ≥ V_ACTIVE.
- `frame_o`, out, 1: one-cycle pulse at the first cycle of line V_ACTIVE.

## Operation
- Counters: `h` counts 0..1343 and wraps to 0; on wrap, `v` increments over 0..805 and wraps to 0.
- Active area: `de0` = (h < H_ACTIVE) && (v < V_ACTIVE).
- hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- vsync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- Fetch:
  - Normal mode: when de0 and h[4:0]==0, register gb_adr_o = v*32 + h[9:5].
  - Double mode: when de0 and h[5:0]==0, register gb_adr_o = (v>>1)*16 + h[9:6]. Each source line is fetched twice, once per displayed line.
  - gb_adr_o holds its value between fetches.
- Serialise:
  - On a load cycle, the shift register takes gb_dat_i.
  - Bit 31 is the leftmost pixel.
  - Normal mode shifts 1 bit per cycle; double mode shifts every 2nd cycle.
  - No further fetch happens until the next word boundary.
- pix_o = shifted bit && de && en_i; it is 0 whenever de_o is 0.
- Address arithmetic is 15-bit unsigned. The maximum address is 24575 in normal mode and 6143 in double mode; no wrap occurs within a frame.

## Timing
- Pipeline:
  - Cycle t: counters.
  - Cycle t+1: gb_adr_o registered.
  - Cycle t+2: gb_dat_i valid and shift register loaded.
  - Cycle t+3: pix_o registered.
- de_o, hsync_o, vsync_o, vblank_o and frame_o are delayed through a 3-stage pipe so all outputs stay mutually aligned at latency 3.
- Reset values:
  - h = v = 0, gb_adr_o = 0, pix_o = 0, de_o = 0, frame_o = 0, vblank_o = 0.
  - hsync_o and vsync_o at their inactive level (1 when SYNC_NEG = 1).
  - The delay pipe is cleared.
- Reset mid-frame: all state returns to reset values in the next cycle. The raster restarts at h=0, v=0, and the first de_o=1 appears 3 cycles after reset deasserts.
- en_i is sampled at the output stage and takes effect on pix_o the same cycle. No fetch is suppressed.
- Simultaneous h and v wrap: v=805→0 and h=1343→0 in the same cycle; the frame restarts cleanly.
- Frame length is exactly 1344*806 = 1083264 cycles.

## Structure
- Shared package `gpu_pkg` holds:
  - The default 1024x768@60 timing constants.
  - VRAM words-per-line constants, 32 and 16.
  - The VRAM address width, 15.
- Natural sub-module: `gpu_timing` (counters plus de/sync/vblank/frame generation). Fetch and serialiser logic stay in `gpu_scanout`.

## Test plan
- Reset: hold wb_rst_i for 5 cycles → hsync_o=1, vsync_o=1, de_o=0, pix_o=0, gb_adr_o=0; first de_o rise occurs 3 cycles after release.
- Timing counts: run one frame.
  - de_o is high for 1024 consecutive cycles per line, across 768 lines.
  - hsync_o is low for 136 cycles, starting 24 cycles after de_o falls.
  - vsync_o is low for 6 lines.
  - frame_o pulses exactly once every 1083264 cycles.
- Pixel order: VRAM model word 0 = 0x80000001, word 1 = 0xFFFFFFFF, others 0.
  - Expected pix_o on line 0: pixel 0 = 1, pixels 1..30 = 0, pixel 31 = 1, pixels 32..63 = 1.
  - pix_o = 0 outside de_o.
- Pixel double: PIXEL_DOUBLE=1, word 0 = 0xC0000000.
  - Pixels 0..3 = 1 on both lines 0 and 1.
  - Fetch addresses on line 2 are 16, 17, …
  - Line 767 fetches address 6143.
- Enable: deassert en_i mid-line → pix_o = 0 on that cycle while de_o and sync are unchanged; reassert → pixels resume on the correct bit.
- Mid-frame reset: assert reset at v=400, h=500 → next frame starts at v=0; gb_adr_o sequence restarts at 0, 1, 2.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared timing defaults, VRAM geometry and small helpers for the Zucker GPU scanout path.
package gpu_pkg;

  localparam int unsigned DEF_H_ACTIVE = 1024;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 136;
  localparam int unsigned DEF_H_BP     = 160;
  localparam int unsigned DEF_V_ACTIVE = 768;
  localparam int unsigned DEF_V_FP     = 3;
  localparam int unsigned DEF_V_SYNC   = 6;
  localparam int unsigned DEF_V_BP     = 29;

  localparam int unsigned WORDS_PER_LINE     = 32;
  localparam int unsigned WORDS_PER_LINE_DBL = 16;
  localparam int unsigned VRAM_AW            = 15;

  localparam int unsigned H_W = 11;
  localparam int unsigned V_W = 10;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic vb;
    logic fr;
  } tim_t;

  localparam tim_t TIM_IDLE = '{de: 1'b0, hs: 1'b0, vs: 1'b0, vb: 1'b0, fr: 1'b0};

  // Converts an active-high sync flag to the pin level for the chosen polarity.
  function automatic logic sync_level(input logic active, input logic neg);
    return active ^ neg;
  endfunction

endpackage

// File: rtl/gpu_timing.sv
// Raster counters with active-area, sync, blanking and frame-pulse decode.
module gpu_timing
  import gpu_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  output logic [9:0]     o_hpos,
  output logic [V_W-1:0] o_vpos,
  output logic           o_de,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_vb,
  output logic           o_fr
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_ZERO   = {H_W{1'b0}};
  localparam logic [H_W-1:0] H_ONE    = H_W'(1);
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_HS_BEG = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] H_HS_END = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_ZERO   = {V_W{1'b0}};
  localparam logic [V_W-1:0] V_ONE    = V_W'(1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_VS_BEG = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] V_VS_END = V_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [H_W-1:0] r_h;
  logic [V_W-1:0] r_v;

  // Raster position; v steps on every h wrap and both wrap together at frame end.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_h <= H_ZERO;
      r_v <= V_ZERO;
    end else if (r_h == H_LAST) begin
      r_h <= H_ZERO;
      r_v <= (r_v == V_LAST) ? V_ZERO : r_v + V_ONE;
    end else begin
      r_h <= r_h + H_ONE;
    end
  end

  assign o_hpos = r_h[9:0];
  assign o_vpos = r_v;
  assign o_de   = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_hs   = (r_h >= H_HS_BEG) && (r_h < H_HS_END);
  assign o_vs   = (r_v >= V_VS_BEG) && (r_v < V_VS_END);
  assign o_vb   = (r_v >= V_ACT);
  assign o_fr   = (r_h == H_ZERO) && (r_v == V_ACT);

endmodule

// File: rtl/gpu_scanout.sv
// Scanout: raster timing, one VRAM word fetch per line-word, 1bpp serialiser with aligned syncs.
module gpu_scanout
  import gpu_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_FP         = DEF_H_FP,
  parameter int unsigned H_SYNC       = DEF_H_SYNC,
  parameter int unsigned H_BP         = DEF_H_BP,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_FP         = DEF_V_FP,
  parameter int unsigned V_SYNC       = DEF_V_SYNC,
  parameter int unsigned V_BP         = DEF_V_BP,
  parameter int unsigned SYNC_NEG     = 1,
  parameter int unsigned PIXEL_DOUBLE = 0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               en_i,
  output logic [VRAM_AW-1:0] gb_adr_o,
  input  logic [31:0]        gb_dat_i,
  output logic               pix_o,
  output logic               de_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               vblank_o,
  output logic               frame_o
);

  localparam logic DBL  = (PIXEL_DOUBLE != 0);
  localparam logic SNEG = (SYNC_NEG != 0);

  logic [9:0]         w_h;
  logic [V_W-1:0]     w_v;
  logic               w_de0, w_hs0, w_vs0, w_vb0, w_fr0;
  tim_t               w_tim0;
  logic               w_fetch;
  logic [VRAM_AW-1:0] w_adr_nxt;
  logic [31:0]        w_src;
  logic [31:0]        w_sh_nxt;

  tim_t        r_tim1, r_tim2;
  logic        r_ld1, r_ld2;
  logic        r_ph1, r_ph2;
  logic [31:0] r_sh;

  gpu_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .o_hpos   (w_h),
    .o_vpos   (w_v),
    .o_de     (w_de0),
    .o_hs     (w_hs0),
    .o_vs     (w_vs0),
    .o_vb     (w_vb0),
    .o_fr     (w_fr0)
  );

  assign w_tim0 = '{de: w_de0, hs: w_hs0, vs: w_vs0, vb: w_vb0, fr: w_fr0};

  // Fetch decision and next address; the address holds between word boundaries.
  always_comb begin
    w_fetch   = 1'b0;
    w_adr_nxt = gb_adr_o;
    if (DBL) begin
      w_fetch = w_de0 && (w_h[5:0] == 6'd0);
      if (w_fetch) begin
        w_adr_nxt = VRAM_AW'(w_v[V_W-1:1]) * VRAM_AW'(WORDS_PER_LINE_DBL) + VRAM_AW'(w_h[9:6]);
      end else begin
        w_adr_nxt = gb_adr_o;
      end
    end else begin
      w_fetch = w_de0 && (w_h[4:0] == 5'd0);
      if (w_fetch) begin
        w_adr_nxt = VRAM_AW'(w_v) * VRAM_AW'(WORDS_PER_LINE) + VRAM_AW'(w_h[9:5]);
      end else begin
        w_adr_nxt = gb_adr_o;
      end
    end
  end

  // Load takes the VRAM word directly so its MSB is shown without an extra stage;
  // in double mode the shift happens only after the odd half of each pixel pair.
  always_comb begin
    w_src    = r_ld2 ? gb_dat_i : r_sh;
    w_sh_nxt = w_src;
    if (!DBL || r_ph2) begin
      w_sh_nxt = {w_src[30:0], 1'b0};
    end else begin
      w_sh_nxt = w_src;
    end
  end

  // Stages 1 and 2: address register plus timing/load/phase delay alongside the VRAM read.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      gb_adr_o <= {VRAM_AW{1'b0}};
      r_tim1   <= TIM_IDLE;
      r_tim2   <= TIM_IDLE;
      r_ld1    <= 1'b0;
      r_ld2    <= 1'b0;
      r_ph1    <= 1'b0;
      r_ph2    <= 1'b0;
    end else begin
      gb_adr_o <= w_adr_nxt;
      r_tim1   <= w_tim0;
      r_tim2   <= r_tim1;
      r_ld1    <= w_fetch;
      r_ld2    <= r_ld1;
      r_ph1    <= w_h[0];
      r_ph2    <= r_ph1;
    end
  end

  // Stage 3: serialiser state and all registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sh     <= 32'h0000_0000;
      pix_o    <= 1'b0;
      de_o     <= 1'b0;
      hsync_o  <= sync_level(1'b0, SNEG);
      vsync_o  <= sync_level(1'b0, SNEG);
      vblank_o <= 1'b0;
      frame_o  <= 1'b0;
    end else begin
      r_sh     <= w_sh_nxt;
      pix_o    <= w_src[31] & r_tim2.de & en_i;
      de_o     <= r_tim2.de;
      hsync_o  <= sync_level(r_tim2.hs, SNEG);
      vsync_o  <= sync_level(r_tim2.vs, SNEG);
      vblank_o <= r_tim2.vb;
      frame_o  <= r_tim2.fr;
    end
  end

endmodule

// File: tb/tb_gpu_scanout.sv
// Directed bench for gpu_scanout: a normal and a pixel-doubled instance with a short frame.
module tb_gpu_scanout;

  localparam int H_TOT = 1344;
  localparam int V_ACT = 8;
  localparam int V_TOT = 12;
  localparam int FRAME = H_TOT * V_TOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [14:0] adr_n, adr_d;
  logic [31:0] dat_n, dat_d;
  logic        pix_n, de_n, hs_n, vs_n, vb_n, fr_n;
  logic        pix_d, de_d, hs_d, vs_d, vb_d, fr_d;
  int          errors = 0;
  int          checks = 0;
  int          n_cyc  = 0;

  always #5 clk = ~clk;

  gpu_scanout #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_n (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .gb_adr_o(adr_n), .gb_dat_i(dat_n),
    .pix_o(pix_n), .de_o(de_n), .hsync_o(hs_n), .vsync_o(vs_n), .vblank_o(vb_n), .frame_o(fr_n));

  gpu_scanout #(.V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIXEL_DOUBLE(1)) dut_d (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .gb_adr_o(adr_d), .gb_dat_i(dat_d),
    .pix_o(pix_d), .de_o(de_d), .hsync_o(hs_d), .vsync_o(vs_d), .vblank_o(vb_d), .frame_o(fr_d));

  function automatic logic [31:0] vram_n(input logic [14:0] a);
    case (a)
      15'd0:   return 32'h8000_0001;
      15'd1:   return 32'hFFFF_FFFF;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] vram_d(input logic [14:0] a);
    case (a)
      15'd0:   return 32'hC000_0000;
      15'd17:  return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Registered-read VRAM models and a count of clock edges since reset release.
  always @(posedge clk) begin
    dat_n <= vram_n(adr_n);
    dat_d <= vram_d(adr_d);
    if (rst) n_cyc <= 0;
    else     n_cyc <= n_cyc + 1;
  end

  // Raster index of the pixel currently on the outputs (three edges behind the counters).
  function automatic int pos();
    return (n_cyc - 3) % FRAME;
  endfunction

  function automatic logic exp_pix_n(input int p);
    int hh, vv;
    logic [31:0] w;
    hh = p % H_TOT;
    vv = p / H_TOT;
    if (hh >= 1024 || vv >= V_ACT) return 1'b0;
    w = vram_n(15'(vv * 32 + hh / 32));
    return w[31 - (hh % 32)];
  endfunction

  function automatic logic exp_pix_d(input int p);
    int hh, vv;
    logic [31:0] w;
    hh = p % H_TOT;
    vv = p / H_TOT;
    if (hh >= 1024 || vv >= V_ACT) return 1'b0;
    w = vram_d(15'((vv / 2) * 16 + hh / 64));
    return w[31 - ((hh % 64) / 2)];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (hs_n !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", hs_n); end
    checks++; if (vs_n !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vs_n); end
    checks++; if (de_n !== 1'b0) begin errors++; $display("FAIL reset_de: got %b want 0", de_n); end
    checks++; if (pix_n !== 1'b0) begin errors++; $display("FAIL reset_pix: got %b want 0", pix_n); end
    checks++; if (adr_n !== 15'd0) begin errors++; $display("FAIL reset_adr: got %0d want 0", adr_n); end
    checks++; if ({vb_n, fr_n} !== 2'b00) begin errors++; $display("FAIL reset_vb_fr: got %b want 00", {vb_n, fr_n}); end
    rst = 1'b0;
    step();
    checks++; if (de_n !== 1'b0) begin errors++; $display("FAIL de_rise_c1: got %b want 0", de_n); end
    step();
    checks++; if (de_n !== 1'b0) begin errors++; $display("FAIL de_rise_c2: got %b want 0", de_n); end
    step();
    checks++; if (de_n !== 1'b1) begin errors++; $display("FAIL de_rise_c3: got %b want 1", de_n); end
    checks++; if (de_d !== 1'b1) begin errors++; $display("FAIL de_rise_dbl: got %b want 1", de_d); end
  endtask

  task automatic test_pixel_order();
    logic e;
    int   bad = 0;
    for (int p = 0; p < 64; p++) begin
      e = (p == 0) || (p == 31) || (p >= 32);
      checks++;
      if (pix_n !== e) begin errors++; $display("FAIL pixel_order[%0d]: got %b want %b", p, pix_n, e); end
      step();
    end
    for (int p = 64; p < H_TOT; p++) begin
      if (pix_n !== 1'b0) bad++;
      if (de_n !== (p < 1024)) bad++;
      step();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL line0_tail: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_timing();
    int p, hh, vv;
    int bad_de = 0, bad_hs = 0, bad_vs = 0, bad_vb = 0, bad_fr = 0, bad_pn = 0, bad_pd = 0;
    int n_de = 0, n_rise = 0, n_hs = 0, n_vs = 0, n_fr = 0, max_n = 0, max_d = 0;
    int fall_i = -1, gap = -1;
    logic prev_de = 1'b0, prev_hs = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      p  = pos();
      hh = p % H_TOT;
      vv = p / H_TOT;
      if (de_n !== ((hh < 1024) && (vv < V_ACT))) bad_de++;
      if (de_d !== de_n) bad_de++;
      if (hs_n !== !((hh >= 1048) && (hh < 1184))) bad_hs++;
      if (vs_n !== !((vv >= 9) && (vv < 11))) bad_vs++;
      if (vb_n !== (vv >= V_ACT)) bad_vb++;
      if (fr_n !== ((hh == 0) && (vv == V_ACT))) bad_fr++;
      if (pix_n !== exp_pix_n(p)) bad_pn++;
      if (pix_d !== exp_pix_d(p)) bad_pd++;
      if (de_n) n_de++;
      if (de_n && !prev_de) n_rise++;
      if (prev_de && !de_n) fall_i = i;
      if (prev_hs && !hs_n && fall_i >= 0) begin gap = i - fall_i; fall_i = -1; end
      if (!hs_n) n_hs++;
      if (!vs_n) n_vs++;
      if (fr_n) n_fr++;
      if (int'(adr_n) > max_n) max_n = int'(adr_n);
      if (int'(adr_d) > max_d) max_d = int'(adr_d);
      prev_de = de_n;
      prev_hs = hs_n;
      step();
    end
    checks++; if (bad_de !== 0) begin errors++; $display("FAIL de_pos: got %0d bad want 0", bad_de); end
    checks++; if (bad_hs !== 0) begin errors++; $display("FAIL hsync_pos: got %0d bad want 0", bad_hs); end
    checks++; if (bad_vs !== 0) begin errors++; $display("FAIL vsync_pos: got %0d bad want 0", bad_vs); end
    checks++; if (bad_vb !== 0) begin errors++; $display("FAIL vblank_pos: got %0d bad want 0", bad_vb); end
    checks++; if (bad_fr !== 0) begin errors++; $display("FAIL frame_pos: got %0d bad want 0", bad_fr); end
    checks++; if (bad_pn !== 0) begin errors++; $display("FAIL pix_frame: got %0d bad want 0", bad_pn); end
    checks++; if (bad_pd !== 0) begin errors++; $display("FAIL pix_frame_dbl: got %0d bad want 0", bad_pd); end
    checks++; if (n_de !== 8 * 1024) begin errors++; $display("FAIL de_count: got %0d want %0d", n_de, 8 * 1024); end
    checks++; if (n_rise !== 8) begin errors++; $display("FAIL de_lines: got %0d want 8", n_rise); end
    checks++; if (n_hs !== 12 * 136) begin errors++; $display("FAIL hsync_count: got %0d want %0d", n_hs, 12 * 136); end
    checks++; if (gap !== 24) begin errors++; $display("FAIL hsync_gap: got %0d want 24", gap); end
    checks++; if (n_vs !== 2 * H_TOT) begin errors++; $display("FAIL vsync_count: got %0d want %0d", n_vs, 2 * H_TOT); end
    checks++; if (n_fr !== 1) begin errors++; $display("FAIL frame_count: got %0d want 1", n_fr); end
    checks++; if (max_n !== 255) begin errors++; $display("FAIL max_adr: got %0d want 255", max_n); end
    checks++; if (max_d !== 63) begin errors++; $display("FAIL max_adr_dbl: got %0d want 63", max_d); end
  endtask

  task automatic test_pixel_double();
    int p, hh, vv, idx;
    for (int i = 0; i < FRAME && pos() != 0; i++) step();
    checks++; if (pos() !== 0) begin errors++; $display("FAIL dbl_sync_wait: got %0d want 0", pos()); end
    for (int i = 0; i < 3 * H_TOT; i++) begin
      p   = pos();
      hh  = p % H_TOT;
      vv  = p / H_TOT;
      idx = p - (2 * H_TOT - 2);
      if (vv < 2 && hh < 5) begin
        checks++;
        if (pix_d !== (hh < 4)) begin errors++; $display("FAIL dbl_pix[%0d,%0d]: got %b want %b", vv, hh, pix_d, hh < 4); end
      end
      if (idx >= 0 && idx < 1024 && ((idx % 64) == 0 || (idx % 64) == 63)) begin
        checks++;
        if (int'(adr_d) !== 16 + idx / 64) begin
          errors++; $display("FAIL dbl_adr[%0d]: got %0d want %0d", idx, adr_d, 16 + idx / 64);
        end
      end
      step();
    end
  endtask

  task automatic test_enable();
    int bad = 0;
    for (int i = 0; i < FRAME && pos() != FRAME - 1; i++) step();
    checks++; if (pos() !== FRAME - 1) begin errors++; $display("FAIL en_sync_wait: got %0d want %0d", pos(), FRAME - 1); end
    en = 1'b0;
    step();
    checks++; if (pix_n !== 1'b0) begin errors++; $display("FAIL en_off_pix: got %b want 0", pix_n); end
    checks++; if ({de_n, hs_n, vs_n} !== 3'b111) begin errors++; $display("FAIL en_off_timing: got %b want 111", {de_n, hs_n, vs_n}); end
    en = 1'b1;
    for (int p = 1; p < 31; p++) begin
      step();
      if (pix_n !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL en_resume_zeros: got %0d bad want 0", bad); end
    step();
    checks++; if (pix_n !== 1'b1) begin errors++; $display("FAIL en_resume_bit31: got %b want 1", pix_n); end
  endtask

  task automatic test_mid_reset();
    logic [14:0] seq[$];
    for (int i = 0; i < FRAME && pos() != 4 * H_TOT + 500; i++) step();
    checks++; if (pos() !== 4 * H_TOT + 500) begin errors++; $display("FAIL mr_sync_wait: got %0d want %0d", pos(), 4 * H_TOT + 500); end
    rst = 1'b1;
    step();
    checks++; if ({de_n, pix_n, vb_n, fr_n} !== 4'b0000) begin errors++; $display("FAIL mr_outputs: got %b want 0000", {de_n, pix_n, vb_n, fr_n}); end
    checks++; if ({hs_n, vs_n} !== 2'b11) begin errors++; $display("FAIL mr_syncs: got %b want 11", {hs_n, vs_n}); end
    checks++; if (adr_n !== 15'd0) begin errors++; $display("FAIL mr_adr: got %0d want 0", adr_n); end
    rst = 1'b0;
    seq.push_back(adr_n);
    for (int i = 1; i <= 100; i++) begin
      step();
      if (adr_n !== seq[$]) seq.push_back(adr_n);
      if (i == 2) begin
        checks++; if (de_n !== 1'b0) begin errors++; $display("FAIL mr_de_c2: got %b want 0", de_n); end
      end
      if (i == 3) begin
        checks++; if (de_n !== 1'b1) begin errors++; $display("FAIL mr_de_c3: got %b want 1", de_n); end
      end
    end
    checks++;
    if (seq.size() < 3) begin
      errors++; $display("FAIL mr_seq_len: got %0d want >=3", seq.size());
    end else if (seq[0] !== 15'd0 || seq[1] !== 15'd1 || seq[2] !== 15'd2) begin
      errors++; $display("FAIL mr_seq: got %0d,%0d,%0d want 0,1,2", seq[0], seq[1], seq[2]);
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    test_reset();
    test_pixel_order();
    test_timing();
    test_pixel_double();
    test_enable();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
